// File: rtl/branch_resolution_unit.sv
// Execute-side branch resolution: in-order queue of predicted branches, predictor
// feedback, mispredict flush/redirect handshake and branch/mispredict statistics.
module branch_resolution_unit #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DEPTH      = 4,
   parameter int unsigned CNT_WIDTH  = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  i_req_valid,
   input  logic [ADDR_WIDTH-1:0] i_req_pc,
   input  logic                  i_req_prediction,
   input  logic [ADDR_WIDTH-1:0] i_req_recovery_target,
   output logic                  o_req_ready,
   input  logic                  i_ex_valid,
   input  logic [ADDR_WIDTH-1:0] i_ex_pc,
   input  logic                  i_ex_taken,
   output logic                  o_fb_valid,
   output logic [ADDR_WIDTH-1:0] o_fb_pc,
   output logic                  o_fb_prediction,
   output logic                  o_fb_outcome,
   output logic                  o_flush,
   output logic                  o_redirect_valid,
   output logic [ADDR_WIDTH-1:0] o_redirect_target,
   input  logic                  i_redirect_ready,
   output logic [CNT_WIDTH-1:0]  o_branch_count,
   output logic [CNT_WIDTH-1:0]  o_mispredict_count,
   output logic                  o_error
);

   localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int unsigned OCC_W = PTR_W + 1;

   typedef struct packed {
      logic [ADDR_WIDTH-1:0] pc;
      logic                  prediction;
      logic [ADDR_WIDTH-1:0] recovery_target;
   } entry_t;

   typedef enum logic {
      S_IDLE,
      S_REDIRECT
   } state_t;

   state_t                state_q, state_d;
   entry_t                mem_q [DEPTH];
   entry_t                mem_d [DEPTH];
   logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
   logic [OCC_W-1:0]      count_q, count_d;
   logic                  fb_valid_q, fb_valid_d;
   logic [ADDR_WIDTH-1:0] fb_pc_q, fb_pc_d;
   logic                  fb_prediction_q, fb_prediction_d;
   logic                  fb_outcome_q, fb_outcome_d;
   logic                  flush_q, flush_d;
   logic                  redirect_valid_q, redirect_valid_d;
   logic [ADDR_WIDTH-1:0] redirect_target_q, redirect_target_d;
   logic [CNT_WIDTH-1:0]  branch_count_q, branch_count_d;
   logic [CNT_WIDTH-1:0]  mispredict_count_q, mispredict_count_d;
   logic                  error_q, error_d;

   logic                  req_ready;
   logic                  push;
   logic                  resolve;
   logic                  mispredict;
   entry_t                head;
   entry_t                new_entry;

   // Ready depends only on registered state; no same-cycle bypass when full.
   assign req_ready = (state_q == S_IDLE) && (count_q < OCC_W'(DEPTH));
   assign head      = mem_q[rd_ptr_q];

   always_comb begin
      state_d            = state_q;
      mem_d              = mem_q;
      rd_ptr_d           = rd_ptr_q;
      wr_ptr_d           = wr_ptr_q;
      count_d            = count_q;
      fb_valid_d         = 1'b0;
      fb_pc_d            = fb_pc_q;
      fb_prediction_d    = fb_prediction_q;
      fb_outcome_d       = fb_outcome_q;
      flush_d            = 1'b0;
      redirect_valid_d   = redirect_valid_q;
      redirect_target_d  = redirect_target_q;
      branch_count_d     = branch_count_q;
      mispredict_count_d = mispredict_count_q;
      error_d            = error_q;
      mispredict         = 1'b0;

      push    = i_req_valid && req_ready;
      resolve = i_ex_valid && (state_q == S_IDLE) && (count_q != '0);

      new_entry.pc              = i_req_pc;
      new_entry.prediction      = i_req_prediction;
      new_entry.recovery_target = i_req_recovery_target;

      case (state_q)
         S_IDLE: begin
            if (i_ex_valid && (count_q == '0)) begin
               error_d = 1'b1;
            end

            if (resolve) begin
               if (head.pc != i_ex_pc) begin
                  error_d = 1'b1;
               end
               fb_valid_d      = 1'b1;
               fb_pc_d         = head.pc;
               fb_prediction_d = head.prediction;
               fb_outcome_d    = i_ex_taken;
               if (branch_count_q != '1) begin
                  branch_count_d = branch_count_q + CNT_WIDTH'(1);
               end
               mispredict = (i_ex_taken != head.prediction);
            end

            if (mispredict) begin
               // Whole queue is wrong path; a same-cycle push is dropped too.
               rd_ptr_d          = '0;
               wr_ptr_d          = '0;
               count_d           = '0;
               flush_d           = 1'b1;
               redirect_valid_d  = 1'b1;
               redirect_target_d = head.recovery_target;
               if (mispredict_count_q != '1) begin
                  mispredict_count_d = mispredict_count_q + CNT_WIDTH'(1);
               end
               state_d = S_REDIRECT;
            end else begin
               if (resolve) begin
                  rd_ptr_d = rd_ptr_q + PTR_W'(1);
               end
               if (push) begin
                  mem_d[wr_ptr_q] = new_entry;
                  wr_ptr_d        = wr_ptr_q + PTR_W'(1);
               end
               case ({push, resolve})
                  2'b10:   count_d = count_q + OCC_W'(1);
                  2'b01:   count_d = count_q - OCC_W'(1);
                  default: count_d = count_q;
               endcase
            end
         end

         S_REDIRECT: begin
            // Decode/execute traffic here is wrong path and is ignored.
            if (i_redirect_ready) begin
               redirect_valid_d = 1'b0;
               state_d          = S_IDLE;
            end
         end

         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q            <= S_IDLE;
         for (int i = 0; i < int'(DEPTH); i++) begin
            mem_q[i] <= '0;
         end
         rd_ptr_q           <= '0;
         wr_ptr_q           <= '0;
         count_q            <= '0;
         fb_valid_q         <= 1'b0;
         fb_pc_q            <= '0;
         fb_prediction_q    <= 1'b0;
         fb_outcome_q       <= 1'b0;
         flush_q            <= 1'b0;
         redirect_valid_q   <= 1'b0;
         redirect_target_q  <= '0;
         branch_count_q     <= '0;
         mispredict_count_q <= '0;
         error_q            <= 1'b0;
      end else begin
         state_q            <= state_d;
         mem_q              <= mem_d;
         rd_ptr_q           <= rd_ptr_d;
         wr_ptr_q           <= wr_ptr_d;
         count_q            <= count_d;
         fb_valid_q         <= fb_valid_d;
         fb_pc_q            <= fb_pc_d;
         fb_prediction_q    <= fb_prediction_d;
         fb_outcome_q       <= fb_outcome_d;
         flush_q            <= flush_d;
         redirect_valid_q   <= redirect_valid_d;
         redirect_target_q  <= redirect_target_d;
         branch_count_q     <= branch_count_d;
         mispredict_count_q <= mispredict_count_d;
         error_q            <= error_d;
      end
   end

   assign o_req_ready        = req_ready;
   assign o_fb_valid         = fb_valid_q;
   assign o_fb_pc            = fb_pc_q;
   assign o_fb_prediction    = fb_prediction_q;
   assign o_fb_outcome       = fb_outcome_q;
   assign o_flush            = flush_q;
   assign o_redirect_valid   = redirect_valid_q;
   assign o_redirect_target  = redirect_target_q;
   assign o_branch_count     = branch_count_q;
   assign o_mispredict_count = mispredict_count_q;
   assign o_error            = error_q;

endmodule

// File: tb/tb_branch_resolution_unit.sv
// Bench for branch_resolution_unit: behavioural queue model plus a feedback
// scoreboard popped whenever the DUT strobes o_fb_valid.
module tb_branch_resolution_unit;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        i_req_valid = 1'b0;
   logic [31:0] i_req_pc = '0;
   logic        i_req_prediction = 1'b0;
   logic [31:0] i_req_recovery_target = '0;
   logic        o_req_ready;
   logic        i_ex_valid = 1'b0;
   logic [31:0] i_ex_pc = '0;
   logic        i_ex_taken = 1'b0;
   logic        o_fb_valid;
   logic [31:0] o_fb_pc;
   logic        o_fb_prediction;
   logic        o_fb_outcome;
   logic        o_flush;
   logic        o_redirect_valid;
   logic [31:0] o_redirect_target;
   logic        i_redirect_ready = 1'b0;
   logic [31:0] o_branch_count;
   logic [31:0] o_mispredict_count;
   logic        o_error;

   branch_resolution_unit #(.ADDR_WIDTH(32), .DEPTH(DEPTH), .CNT_WIDTH(32)) dut (
      .clk(clk), .rst(rst),
      .i_req_valid(i_req_valid), .i_req_pc(i_req_pc), .i_req_prediction(i_req_prediction),
      .i_req_recovery_target(i_req_recovery_target), .o_req_ready(o_req_ready),
      .i_ex_valid(i_ex_valid), .i_ex_pc(i_ex_pc), .i_ex_taken(i_ex_taken),
      .o_fb_valid(o_fb_valid), .o_fb_pc(o_fb_pc), .o_fb_prediction(o_fb_prediction),
      .o_fb_outcome(o_fb_outcome), .o_flush(o_flush),
      .o_redirect_valid(o_redirect_valid), .o_redirect_target(o_redirect_target),
      .i_redirect_ready(i_redirect_ready),
      .o_branch_count(o_branch_count), .o_mispredict_count(o_mispredict_count),
      .o_error(o_error)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [31:0] pc;
      logic        pred;
      logic [31:0] rt;
   } ent_t;

   typedef struct packed {
      logic [31:0] pc;
      logic        pred;
      logic        outcome;
   } fb_t;

   ent_t        m_q[$];
   fb_t         exp_q[$];
   logic        m_redir = 1'b0;
   logic [31:0] m_target = '0;
   logic        m_err = 1'b0;
   int          m_bc = 0;
   int          m_mc = 0;
   int          n_chk = 0;
   int          n_pass = 0;

   // Scoreboard: every feedback strobe must match the oldest expected resolution.
   always @(negedge clk) begin
      fb_t e;
      if (o_fb_valid === 1'b1) begin
         n_chk++;
         if (exp_q.size() == 0) begin
            $display("FAIL fb_unexpected: got fb pc=%h pred=%b out=%b, want no feedback",
                     o_fb_pc, o_fb_prediction, o_fb_outcome);
         end else begin
            e = exp_q.pop_front();
            if ({o_fb_pc, o_fb_prediction, o_fb_outcome} !== {e.pc, e.pred, e.outcome})
               $display("FAIL fb_data: got pc=%h pred=%b out=%b, want pc=%h pred=%b out=%b",
                        o_fb_pc, o_fb_prediction, o_fb_outcome, e.pc, e.pred, e.outcome);
            else
               n_pass++;
         end
      end
   end

   // Drive one cycle of stimulus and advance the reference model by the same edge.
   task automatic cycle(input logic rv, input logic [31:0] rpc, input logic rpred,
                        input logic [31:0] rrt, input logic ev, input logic [31:0] epc,
                        input logic et, input logic rdy);
      logic idle, ready, mis;
      ent_t e, n;
      fb_t  f;
      i_req_valid = rv; i_req_pc = rpc; i_req_prediction = rpred; i_req_recovery_target = rrt;
      i_ex_valid = ev; i_ex_pc = epc; i_ex_taken = et; i_redirect_ready = rdy;
      idle  = !m_redir;
      ready = idle && (m_q.size() < DEPTH);
      mis   = 1'b0;
      if (idle && ev) begin
         if (m_q.size() == 0) begin
            m_err = 1'b1;
         end else begin
            e = m_q.pop_front();
            if (e.pc != epc) m_err = 1'b1;
            f.pc = e.pc; f.pred = e.pred; f.outcome = et;
            exp_q.push_back(f);
            m_bc++;
            if (et != e.pred) begin
               mis = 1'b1;
               m_mc++;
               m_target = e.rt;
               m_q.delete();
            end
         end
      end
      if (ready && rv && !mis) begin
         n.pc = rpc; n.pred = rpred; n.rt = rrt;
         m_q.push_back(n);
      end
      if (!idle && rdy) m_redir = 1'b0;
      if (mis) m_redir = 1'b1;
      @(posedge clk); #1;
      i_req_valid = 1'b0; i_ex_valid = 1'b0; i_redirect_ready = 1'b0;
   endtask

   task automatic apply_reset();
      rst = 1'b1;
      i_req_valid = 1'b0; i_ex_valid = 1'b0; i_redirect_ready = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      m_q.delete(); exp_q.delete();
      m_redir = 1'b0; m_target = '0; m_err = 1'b0; m_bc = 0; m_mc = 0;
   endtask

   task automatic test_reset();
      apply_reset();
      n_chk++; if ({o_fb_valid, o_flush, o_redirect_valid, o_error} !== 4'b0000)
         $display("FAIL rst_flags: got %b want 0000", {o_fb_valid, o_flush, o_redirect_valid, o_error});
      else n_pass++;
      n_chk++; if ({o_branch_count, o_mispredict_count} !== 64'd0)
         $display("FAIL rst_counts: got %0d/%0d want 0/0", o_branch_count, o_mispredict_count);
      else n_pass++;
      n_chk++; if (o_req_ready !== 1'b1)
         $display("FAIL rst_ready: got %b want 1", o_req_ready);
      else n_pass++;
   endtask

   task automatic test_basic();
      cycle(1, 32'h100, 1, 32'h108, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 32'h100, 1, 0);
      n_chk++; if ({o_fb_valid, o_flush, o_redirect_valid} !== 3'b100)
         $display("FAIL basic_strobes: got %b want 100", {o_fb_valid, o_flush, o_redirect_valid});
      else n_pass++;
      n_chk++; if (o_branch_count !== 32'(m_bc) || o_mispredict_count !== 32'(m_mc))
         $display("FAIL basic_counts: got %0d/%0d want %0d/%0d", o_branch_count, o_mispredict_count, m_bc, m_mc);
      else n_pass++;
   endtask

   task automatic test_full();
      for (int i = 0; i < DEPTH; i++) begin
         cycle(1, 32'h10 + 32'(4 * i), 0, 32'h90, 0, 0, 0, 0);
         n_chk++; if (o_req_ready !== (m_q.size() < DEPTH))
            $display("FAIL full_fill_ready%0d: got %b want %b", i, o_req_ready, m_q.size() < DEPTH);
         else n_pass++;
      end
      cycle(1, 32'h20, 0, 32'h90, 1, 32'h10, 0, 0);
      n_chk++; if (o_req_ready !== 1'b1 || m_q.size() != 3)
         $display("FAIL full_refused_ready: got %b want 1", o_req_ready);
      else n_pass++;
      for (int i = 0; i < 3; i++) cycle(0, 0, 0, 0, 1, m_q[0].pc, m_q[0].pred, 0);
      for (int i = 0; i < DEPTH; i++) begin
         n_chk++; if (o_req_ready !== 1'b1)
            $display("FAIL full_refill_ready%0d: got %b want 1", i, o_req_ready);
         else n_pass++;
         cycle(1, 32'h40 + 32'(4 * i), 1, 32'h90, 0, 0, 0, 0);
      end
      n_chk++; if (o_req_ready !== 1'b0)
         $display("FAIL full_refill_final: got %b want 0", o_req_ready);
      else n_pass++;
      while (m_q.size() > 0) cycle(0, 0, 0, 0, 1, m_q[0].pc, m_q[0].pred, 0);
   endtask

   task automatic test_mispredict();
      cycle(1, 32'h200, 0, 32'h240, 0, 0, 0, 0);
      cycle(1, 32'h204, 0, 32'h250, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 32'h200, 1, 0);
      n_chk++; if ({o_flush, o_redirect_valid, o_req_ready} !== 3'b110 || o_redirect_target !== 32'h240)
         $display("FAIL mis_start: got flush/rv/rdy=%b tgt=%h want 110 tgt=%h",
                  {o_flush, o_redirect_valid, o_req_ready}, o_redirect_target, m_target);
      else n_pass++;
      for (int i = 0; i < 3; i++) begin
         cycle(1, 32'h300, 1, 32'h304, 1, 32'h204, 1, 0);
         n_chk++; if ({o_flush, o_redirect_valid, o_error} !== 3'b010 || o_redirect_target !== m_target)
            $display("FAIL mis_hold%0d: got flush/rv/err=%b tgt=%h want 010 tgt=%h",
                     i, {o_flush, o_redirect_valid, o_error}, o_redirect_target, m_target);
         else n_pass++;
      end
      cycle(0, 0, 0, 0, 0, 0, 0, 1);
      n_chk++; if ({o_redirect_valid, o_req_ready} !== 2'b01 || o_mispredict_count !== 32'(m_mc))
         $display("FAIL mis_release: got rv/rdy=%b mc=%0d want 01 mc=%0d",
                  {o_redirect_valid, o_req_ready}, o_mispredict_count, m_mc);
      else n_pass++;
   endtask

   task automatic test_empty_error();
      cycle(0, 0, 0, 0, 1, 32'h204, 0, 0);
      n_chk++; if (o_error !== 1'b1 || o_fb_valid !== 1'b0)
         $display("FAIL empty_err: got err=%b fb=%b want 1 0", o_error, o_fb_valid);
      else n_pass++;
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      n_chk++; if (o_error !== m_err)
         $display("FAIL empty_err_sticky: got %b want %b", o_error, m_err);
      else n_pass++;
      apply_reset();
      n_chk++; if ({o_error, o_branch_count, o_mispredict_count} !== 65'd0)
         $display("FAIL empty_err_reset: got err=%b bc=%0d mc=%0d want 0", o_error, o_branch_count, o_mispredict_count);
      else n_pass++;
   endtask

   task automatic test_pc_mismatch();
      cycle(1, 32'h300, 1, 32'h340, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 32'h304, 1, 0);
      n_chk++; if ({o_error, o_fb_valid, o_flush} !== 3'b110 || o_fb_pc !== 32'h300)
         $display("FAIL pcmm: got err/fb/flush=%b pc=%h want 110 pc=300", {o_error, o_fb_valid, o_flush}, o_fb_pc);
      else n_pass++;
      apply_reset();
   endtask

   task automatic test_reset_redirect();
      cycle(1, 32'h400, 1, 32'h480, 0, 0, 0, 0);
      cycle(0, 0, 0, 0, 1, 32'h400, 0, 0);
      n_chk++; if (o_redirect_valid !== 1'b1 || o_redirect_target !== 32'h480)
         $display("FAIL rr_redirect: got rv=%b tgt=%h want 1 tgt=480", o_redirect_valid, o_redirect_target);
      else n_pass++;
      apply_reset();
      n_chk++; if ({o_redirect_valid, o_flush, o_req_ready} !== 3'b001 || {o_branch_count, o_mispredict_count} !== 64'd0)
         $display("FAIL rr_after_reset: got rv/fl/rdy=%b bc=%0d mc=%0d want 001 0 0",
                  {o_redirect_valid, o_flush, o_req_ready}, o_branch_count, o_mispredict_count);
      else n_pass++;
      cycle(0, 0, 0, 0, 1, 32'h400, 1, 0);
      n_chk++; if (o_error !== 1'b1 || o_fb_valid !== 1'b0)
         $display("FAIL rr_queue_empty: got err=%b fb=%b want 1 0", o_error, o_fb_valid);
      else n_pass++;
      apply_reset();
   endtask

   task automatic test_back_to_back();
      logic p;
      p = 1'($urandom_range(0, 1));
      cycle(1, 32'h1000, p, 32'h2000, 0, 0, 0, 0);
      for (int i = 1; i < 8; i++) begin
         p = 1'($urandom_range(0, 1));
         cycle(1, 32'h1000 + 32'(4 * i), p, 32'h2000, 1, m_q[0].pc, m_q[0].pred, 0);
         n_chk++; if ({o_fb_valid, o_flush, o_req_ready} !== 3'b101)
            $display("FAIL b2b_cycle%0d: got fb/fl/rdy=%b want 101", i, {o_fb_valid, o_flush, o_req_ready});
         else n_pass++;
      end
      cycle(0, 0, 0, 0, 1, m_q[0].pc, m_q[0].pred, 0);
      cycle(0, 0, 0, 0, 0, 0, 0, 0);
      n_chk++; if (o_branch_count !== 32'(m_bc) || o_mispredict_count !== 32'(m_mc) || o_error !== 1'b0)
         $display("FAIL b2b_counts: got bc=%0d mc=%0d err=%b want %0d %0d 0",
                  o_branch_count, o_mispredict_count, o_error, m_bc, m_mc);
      else n_pass++;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_full();
      test_mispredict();
      test_empty_error();
      test_pc_mismatch();
      test_reset_redirect();
      test_back_to_back();
      n_chk++; if (exp_q.size() != 0)
         $display("FAIL fb_missing: got %0d unconsumed expectations want 0", exp_q.size());
      else n_pass++;
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
